// File: rtl/batalha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : batalha_pkg
// Description : Shared piece codes, board defaults, ship length lookup and
//               placement FSM states for the battleship board logic.
// Revision    : 1.0 - initial release
// ============================================================================
package batalha_pkg;

    localparam int LADO_PADRAO  = 8;
    localparam int FROTA_PADRAO = 11;

    localparam logic [2:0] AGUA         = 3'd0;
    localparam logic [2:0] SUBMARINO    = 3'd1;
    localparam logic [2:0] CRUZADOR     = 3'd2;
    localparam logic [2:0] HIDROAVIAO   = 3'd3;
    localparam logic [2:0] ENCOURACADO  = 3'd4;
    localparam logic [2:0] PORTA_AVIOES = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        VERIFICA = 3'd1,
        GRAVA    = 3'd2,
        FIM      = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    // Ship length equals its code for legal pieces; 0 marks an illegal code.
    function automatic logic [2:0] comprimento(input logic [2:0] tipo);
        case (tipo)
            SUBMARINO, CRUZADOR, HIDROAVIAO, ENCOURACADO, PORTA_AVIOES:
                comprimento = tipo;
            default:
                comprimento = AGUA;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_celula_navio.sv
`default_nettype none
// ============================================================================
// Module      : calc_celula_navio
// Description : Combinational coordinates of cell k of a ship, plus an
//               off-board flag. Signed 5-bit arithmetic, no wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_celula_navio
    import batalha_pkg::*;
#(
    parameter int LADO = LADO_PADRAO
)
(
    input  logic [2:0]        i_tipo,
    input  logic [2:0]        i_x1,
    input  logic [2:0]        i_y1,
    input  logic              i_direcao,
    input  logic              i_orientacao,
    input  logic [2:0]        i_k,
    output logic signed [4:0] o_x,
    output logic signed [4:0] o_y,
    output logic              o_fora_limite
);

    localparam logic signed [4:0] c_max_coord = 5'(LADO - 1);

    logic signed [4:0] w_k;
    logic signed [4:0] w_passo;
    logic signed [4:0] w_perp;
    logic signed [4:0] w_ax;
    logic signed [4:0] w_ay;

    always_comb begin
        w_k     = signed'({2'b00, i_k});
        w_passo = i_orientacao ? -w_k : w_k;
        // Only the seaplane's middle cell sticks out, always towards +1.
        w_perp  = (i_tipo == HIDROAVIAO && i_k == 3'd1) ? 5'sd1 : 5'sd0;
        w_ax    = signed'({2'b00, i_x1});
        w_ay    = signed'({2'b00, i_y1});
        if (!i_direcao) begin
            o_x = w_ax + w_passo;
            o_y = w_ay + w_perp;
        end else begin
            o_x = w_ax + w_perp;
            o_y = w_ay + w_passo;
        end
        o_fora_limite = (o_x < 5'sd0) || (o_x > c_max_coord) ||
                        (o_y < 5'sd0) || (o_y > c_max_coord);
    end

endmodule
`default_nettype wire

// File: rtl/registra_tabuleiro.sv
`default_nettype none
// ============================================================================
// Module      : registra_tabuleiro
// Description : Expands placement requests into board cells, rejects
//               off-board/overlapping ships, stores both players' boards.
//               Optional macro ADJACENCY_CHECK_EN forbids touching ships.
// Revision    : 1.0 - initial release
// ============================================================================
module registra_tabuleiro
    import batalha_pkg::*;
#(
    parameter int LADO  = LADO_PADRAO,
    parameter int FROTA = FROTA_PADRAO
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valida,
    input  logic [2:0] tipo,
    input  logic       jogador,
    input  logic [2:0] X1,
    input  logic [2:0] Y1,
    input  logic       direcao,
    input  logic       orientacao,
    input  logic       limpa,
    input  logic       rd_jogador,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic [2:0] rd_tipo,
    output logic       busy,
    output logic       conflito,
    output logic       gravado,
    output logic [1:0] frota_completa
);

    localparam int              c_cw    = $clog2(FROTA + 1);
    localparam logic [c_cw-1:0] c_frota = c_cw'(FROTA);

    estado_t           r_estado;
    estado_t           w_prox;
    logic [2:0]        r_tipo;
    logic              r_jog;
    logic [2:0]        r_x1;
    logic [2:0]        r_y1;
    logic              r_dir;
    logic              r_ori;
    logic [2:0]        r_k;
    logic [2:0]        r_tab [0:1][0:LADO-1][0:LADO-1];
    logic [c_cw-1:0]   r_cont [0:1];
    logic [1:0]        r_frota;
    logic              r_conflito;
    logic              r_gravado;

    logic signed [4:0] w_x;
    logic signed [4:0] w_y;
    logic [2:0]        w_cx;
    logic [2:0]        w_cy;
    logic [2:0]        w_len;
    logic              w_fora;
    logic              w_vizinho;
    logic              w_ruim;
    logic              w_ultimo;
    logic              w_busy;
    logic              w_aceita;
    logic              w_legal;

    calc_celula_navio #(
        .LADO          (LADO)
    ) u_celula (
        .i_tipo        (r_tipo),
        .i_x1          (r_x1),
        .i_y1          (r_y1),
        .i_direcao     (r_dir),
        .i_orientacao  (r_ori),
        .i_k           (r_k),
        .o_x           (w_x),
        .o_y           (w_y),
        .o_fora_limite (w_fora)
    );

    assign w_cx     = 3'(w_x);
    assign w_cy     = 3'(w_y);
    assign w_len    = comprimento(r_tipo);
    assign w_ultimo = (r_k == w_len - 3'd1);
    assign w_busy   = (r_estado == VERIFICA) || (r_estado == GRAVA);
    assign w_aceita = valida && !w_busy;
    assign w_legal  = (comprimento(tipo) != AGUA) && (r_cont[jogador] != c_frota);

`ifdef ADJACENCY_CHECK_EN
    always_comb begin
        int nx;
        int ny;
        w_vizinho = 1'b0;
        nx        = 0;
        ny        = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(w_x) + dx;
                ny = int'(w_y) + dy;
                if (nx >= 0 && nx < LADO && ny >= 0 && ny < LADO) begin
                    if (r_tab[r_jog][ny[2:0]][nx[2:0]] != AGUA) begin
                        w_vizinho = 1'b1;
                    end
                end
            end
        end
    end
`else
    assign w_vizinho = 1'b0;
`endif

    // Cell contents are irrelevant when off-board; the OR masks the alias read.
    assign w_ruim = w_fora || (r_tab[r_jog][w_cy][w_cx] != AGUA) || w_vizinho;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            VERIFICA: begin
                if (w_ruim) begin
                    w_prox = FALHA;
                end else if (w_ultimo) begin
                    w_prox = GRAVA;
                end
            end
            GRAVA: begin
                if (w_ultimo) begin
                    w_prox = FIM;
                end
            end
            default: begin
                if (w_aceita) begin
                    w_prox = w_legal ? VERIFICA : FALHA;
                end else begin
                    w_prox = OCIOSO;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_tipo     <= AGUA;
            r_jog      <= 1'b0;
            r_x1       <= 3'd0;
            r_y1       <= 3'd0;
            r_dir      <= 1'b0;
            r_ori      <= 1'b0;
            r_k        <= 3'd0;
            r_frota    <= 2'b00;
            r_conflito <= 1'b0;
            r_gravado  <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                r_cont[j] <= '0;
                for (int y = 0; y < LADO; y++) begin
                    for (int x = 0; x < LADO; x++) begin
                        r_tab[j][y][x] <= AGUA;
                    end
                end
            end
        end else if (limpa) begin
            r_estado   <= OCIOSO;
            r_k        <= 3'd0;
            r_frota    <= 2'b00;
            r_conflito <= 1'b0;
            r_gravado  <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                r_cont[j] <= '0;
                for (int y = 0; y < LADO; y++) begin
                    for (int x = 0; x < LADO; x++) begin
                        r_tab[j][y][x] <= AGUA;
                    end
                end
            end
        end else begin
            r_estado  <= w_prox;
            r_gravado <= (w_prox == FIM);
            if (w_aceita) begin
                r_tipo     <= tipo;
                r_jog      <= jogador;
                r_x1       <= X1;
                r_y1       <= Y1;
                r_dir      <= direcao;
                r_ori      <= orientacao;
                r_k        <= 3'd0;
                r_conflito <= 1'b0;
            end
            if (w_prox == FALHA) begin
                r_conflito <= 1'b1;
            end
            case (r_estado)
                VERIFICA: begin
                    r_k <= w_ultimo ? 3'd0 : r_k + 3'd1;
                end
                GRAVA: begin
                    r_tab[r_jog][w_cy][w_cx] <= r_tipo;
                    r_k <= r_k + 3'd1;
                    // Count on the last write so FIM already sees the new total.
                    if (w_ultimo) begin
                        r_cont[r_jog]  <= r_cont[r_jog] + c_cw'(1);
                        r_frota[r_jog] <= ((r_cont[r_jog] + c_cw'(1)) == c_frota);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_tipo        = r_tab[rd_jogador][rd_y][rd_x];
    assign busy           = w_busy;
    assign conflito       = r_conflito;
    assign gravado        = r_gravado;
    assign frota_completa = r_frota;

endmodule
`default_nettype wire

// File: tb/tb_registra_tabuleiro.sv
`default_nettype none
// ============================================================================
// Module      : tb_registra_tabuleiro
// Description : Self-checking bench for registra_tabuleiro; a board model
//               predicts each placement outcome and its event cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registra_tabuleiro;

    localparam int LADO  = 8;
    localparam int FROTA = 11;

    typedef struct {
        bit sucesso;
        int ciclo;
    } esperado_t;

    logic       clk;
    logic       reset;
    logic       valida;
    logic [2:0] tipo;
    logic       jogador;
    logic [2:0] X1;
    logic [2:0] Y1;
    logic       direcao;
    logic       orientacao;
    logic       limpa;
    logic       rd_jogador;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [2:0] rd_tipo;
    logic       busy;
    logic       conflito;
    logic       gravado;
    logic [1:0] frota_completa;

    int        n_testes = 0;
    int        n_falhas = 0;
    int        cyc      = 0;
    int        mb [2][LADO][LADO];
    int        mc [2];
    esperado_t fila [$];
    esperado_t e;
    logic      conf_ant = 1'b0;

    registra_tabuleiro dut (
        .clk            (clk),
        .reset          (reset),
        .valida         (valida),
        .tipo           (tipo),
        .jogador        (jogador),
        .X1             (X1),
        .Y1             (Y1),
        .direcao        (direcao),
        .orientacao     (orientacao),
        .limpa          (limpa),
        .rd_jogador     (rd_jogador),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_tipo        (rd_tipo),
        .busy           (busy),
        .conflito       (conflito),
        .gravado        (gravado),
        .frota_completa (frota_completa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic verifica(input string tag, input int obs, input int esp);
        n_testes++;
        if (obs != esp) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0d esperado=%0d (ciclo %0d)", tag, obs, esp, cyc);
        end
    endtask

    // Scoreboard: every gravado pulse or conflito rise consumes one prediction.
    always @(negedge clk) begin
        if (reset && (gravado || (conflito && !conf_ant))) begin
            verifica("evento_previsto", int'(fila.size() > 0), 1);
            if (fila.size() > 0) begin
                e = fila.pop_front();
                verifica("tipo_evento", int'(gravado), int'(e.sucesso));
                verifica("ciclo_evento", cyc, e.ciclo);
            end
        end
        conf_ant = conflito;
    end

    task automatic limpa_modelo();
        for (int j = 0; j < 2; j++) begin
            mc[j] = 0;
            for (int y = 0; y < LADO; y++)
                for (int x = 0; x < LADO; x++)
                    mb[j][y][x] = 0;
        end
    endtask

`ifdef ADJACENCY_CHECK_EN
    function automatic bit vizinho(input int j, input int x, input int y);
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (x + dx >= 0 && x + dx < LADO && y + dy >= 0 && y + dy < LADO)
                    if (mb[j][y+dy][x+dx] != 0) return 1'b1;
        return 1'b0;
    endfunction
`endif

    task automatic espera_fila();
        for (int i = 0; i < 40 && fila.size() > 0; i++) @(negedge clk);
        verifica("fila_vazia", fila.size(), 0);
        fila.delete();
    endtask

    task automatic compara_tabuleiro();
        for (int j = 0; j < 2; j++)
            for (int y = 0; y < LADO; y++)
                for (int x = 0; x < LADO; x++) begin
                    rd_jogador = j[0];
                    rd_x       = 3'(x);
                    rd_y       = 3'(y);
                    #1;
                    verifica($sformatf("celula_j%0d_x%0d_y%0d", j, x, y), rd_tipo, mb[j][y][x]);
                end
    endtask

    task automatic coloca(input int t, input int j, input int x, input int y,
                          input int d, input int o, input bit extra);
        int len;
        int lat;
        bit ok;
        int cx [5];
        int cy [5];
        len = (t >= 1 && t <= 5) ? t : 0;
        ok  = (len != 0) && (mc[j] < FROTA);
        lat = 1;
        for (int k = 0; ok && k < len; k++) begin
            int al;
            int px;
            int py;
            al = o ? -k : k;
            px = x + (d ? 0 : al);
            py = y + (d ? al : 0);
            if (t == 3 && k == 1) begin
                if (d) px++; else py++;
            end
            cx[k] = px;
            cy[k] = py;
            if (px < 0 || px >= LADO || py < 0 || py >= LADO) begin
                ok = 1'b0; lat = k + 2;
            end else if (mb[j][py][px] != 0) begin
                ok = 1'b0; lat = k + 2;
            end
`ifdef ADJACENCY_CHECK_EN
            else if (vizinho(j, px, py)) begin
                ok = 1'b0; lat = k + 2;
            end
`endif
        end
        if (ok) begin
            lat = 2 * len + 1;
            for (int k = 0; k < len; k++) mb[j][cy[k]][cx[k]] = t;
            mc[j]++;
        end
        @(negedge clk);
        tipo       = 3'(t);
        jogador    = j[0];
        X1         = 3'(x);
        Y1         = 3'(y);
        direcao    = d[0];
        orientacao = o[0];
        valida     = 1'b1;
        fila.push_back('{sucesso: ok, ciclo: cyc + lat});
        @(posedge clk);
        #1 valida = 1'b0;
        if (extra) begin
            @(negedge clk);
            @(negedge clk);
            verifica("busy_ocupado", busy, 1);
            tipo = 3'd1; X1 = 3'd7; Y1 = 3'd7;
            valida = 1'b1;
            @(posedge clk);
            #1 valida = 1'b0;
        end
        espera_fila();
        verifica("conflito_nivel", conflito, int'(!ok));
        verifica("busy_livre", busy, 0);
        verifica("frota", frota_completa, {int'(mc[1] == FROTA), int'(mc[0] == FROTA)});
    endtask

    initial begin
        int t0;
        reset = 1'b0; valida = 1'b0; tipo = 3'd0; jogador = 1'b0; X1 = 3'd0; Y1 = 3'd0;
        direcao = 1'b0; orientacao = 1'b0; limpa = 1'b0;
        rd_jogador = 1'b0; rd_x = 3'd0; rd_y = 3'd0;
        limpa_modelo();
        repeat (3) @(negedge clk);
        verifica("reset_busy", busy, 0);
        verifica("reset_conflito", conflito, 0);
        verifica("reset_gravado", gravado, 0);
        verifica("reset_frota", frota_completa, 0);
        reset = 1'b1;
        compara_tabuleiro();

        coloca(2, 0, 1, 1, 0, 0, 1'b0);     // cruzador
        coloca(5, 0, 5, 0, 0, 0, 1'b0);     // porta-avioes off board at k=3
        coloca(1, 0, 2, 1, 0, 0, 1'b0);     // overlap
        coloca(1, 1, 2, 1, 0, 0, 1'b0);     // independent board
        coloca(1, 0, 3, 1, 0, 0, 1'b0);     // touches cruzador
        compara_tabuleiro();

        begin
            int lista [10][5] = '{'{4,7,6,0,1}, '{1,4,0,0,0}, '{1,6,0,0,0}, '{1,6,2,0,0},
                                  '{1,0,4,0,0}, '{1,2,4,0,0}, '{1,4,4,0,0}, '{1,6,4,0,0},
                                  '{1,0,6,0,0}, '{1,2,6,0,0}};
            for (int i = 0; i < 10 && mc[0] < FROTA; i++)
                coloca(lista[i][0], 0, lista[i][1], lista[i][2], lista[i][3], lista[i][4], 1'b0);
        end
        coloca(1, 0, 0, 2, 0, 0, 1'b0);     // twelfth ship
        compara_tabuleiro();

        // limpa in the middle of GRAVA of an encouracado
        @(negedge clk);
        tipo = 3'd4; jogador = 1'b1; X1 = 3'd0; Y1 = 3'd7; direcao = 1'b0; orientacao = 1'b0;
        valida = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 valida = 1'b0;
        while (cyc < t0 + 7) @(negedge clk);
        rd_jogador = 1'b1; rd_x = 3'd1; rd_y = 3'd7;
        #1 verifica("parcial_gravado", rd_tipo, 4);
        verifica("busy_grava", busy, 1);
        limpa = 1'b1;
        @(posedge clk);
        #1 limpa = 1'b0;
        @(negedge clk);
        verifica("limpa_busy", busy, 0);
        verifica("limpa_conflito", conflito, 0);
        verifica("limpa_gravado", gravado, 0);
        verifica("limpa_frota", frota_completa, 0);
        limpa_modelo();
        compara_tabuleiro();

        coloca(3, 0, 2, 3, 1, 1, 1'b1);     // hidroaviao with ignored second valida
        compara_tabuleiro();
        coloca(0, 0, 0, 0, 0, 0, 1'b0);     // illegal tipo 0
        coloca(1, 0, 7, 7, 0, 0, 1'b0);
        coloca(7, 1, 0, 0, 0, 0, 1'b0);     // illegal tipo 7
        repeat (3) @(negedge clk);
        verifica("conflito_mantido", conflito, 1);

        // asynchronous reset in the middle of a check
        @(negedge clk);
        tipo = 3'd5; jogador = 1'b1; X1 = 3'd0; Y1 = 3'd0; direcao = 1'b0; orientacao = 1'b0;
        valida = 1'b1;
        @(posedge clk);
        #1 valida = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        verifica("reset_assinc_busy", busy, 0);
        verifica("reset_assinc_conflito", conflito, 0);
        @(negedge clk);
        reset = 1'b1;
        limpa_modelo();
        compara_tabuleiro();

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
`default_nettype wire
